// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift-register sequencer:
// datapath select codes, FSM states and command opcodes.
package usr_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

endpackage

// File: rtl/usr_seq_if.sv
// Command channel of the shift-register sequencer: valid/ready handshake
// carrying opcode, shift count and parallel load word.
interface usr_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/usr_core.sv
// Universal shift-register datapath: hold, shift right, shift left or
// parallel load, chosen each cycle by the select code.
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  sel_t             select,
    input  logic [WIDTH-1:0] p_din,
    input  logic             ser_in,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    always_comb begin
        dout_d = dout_q;
        case (select)
            SEL_SHR:  dout_d = {ser_in, dout_q[WIDTH-1:1]};
            SEL_SHL:  dout_d = {dout_q[WIDTH-2:0], ser_in};
            SEL_LOAD: dout_d = p_din;
            default:  dout_d = dout_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/usr_seq.sv
// Command sequencer around the universal shift register: accepts one command,
// runs it to completion, pulses done for one cycle and returns to IDLE.
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    usr_seq_if.slave         cmd,
    input  logic             ser_in,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    state_t           state_d, state_q;
    logic [1:0]       op_d, op_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] data_d, data_q;
    sel_t             select;

    // Command fields are captured only on accept, so the running command is
    // immune to later changes on the channel.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        select  = SEL_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d   = cmd.cmd_op;
                    cnt_d  = cmd.cmd_count;
                    data_d = cmd.cmd_data;
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if ((cmd.cmd_op != OP_NOP) && (cmd.cmd_count != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                select  = SEL_LOAD;
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                select = (op_q == OP_SHR) ? SEL_SHR : SEL_SHL;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    usr_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .select (select),
        .p_din  (data_q),
        .ser_in (ser_in),
        .dout   (dout)
    );

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign ser_out_l     = dout[WIDTH-1];
    assign ser_out_r     = dout[0];

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq: load, both shift directions, zero-count/NOP,
// reset mid-shift and a held request, with hand-computed expectations.
module tb_usr_seq;

    logic       clk;
    logic       rst;
    logic       ser_in;
    logic [3:0] dout;
    logic       ser_out_l;
    logic       ser_out_r;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int accepts = 0;
    int accepts_base;

    usr_seq_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

    usr_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if.slave),
        .ser_in    (ser_in),
        .dout      (dout),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge, so the values seen at the edge are stable.
    always @(posedge clk) begin
        if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) accepts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                 input logic [2:0] count, input logic [3:0] data);
        cmd_if.cmd_valid = valid;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_count = count;
        cmd_if.cmd_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst    = 1'b1;
        ser_in = 1'b0;
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        tick();
        tick();
        checkOutput("reset_dout", dout, 4'h0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);

        // Request during reset must not be taken
        applyStimulus(1'b1, 2'b11, 3'd0, 4'hF);
        tick();
        checkOutput("rst_noaccept_dout", dout, 4'h0);
        checkOutput("rst_noaccept_busy", busy, 1'b0);
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        rst = 1'b0;
        tick();
        checkOutput("idle_ready", cmd_if.cmd_ready, 1'b1);

        // Load 1101
        $display("[TB] load");
        applyStimulus(1'b1, 2'b11, 3'd0, 4'b1101);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
        checkOutput("load_e0_ready", cmd_if.cmd_ready, 1'b0);
        checkOutput("load_e0_busy", busy, 1'b1);
        checkOutput("load_e0_done", done, 1'b0);
        checkOutput("load_e0_dout", dout, 4'h0);
        tick();
        checkOutput("load_e1_dout", dout, 4'b1101);
        checkOutput("load_e1_done", done, 1'b1);
        checkOutput("load_e1_ready", cmd_if.cmd_ready, 1'b0);
        tick();
        checkOutput("load_e2_done", done, 1'b0);
        checkOutput("load_e2_ready", cmd_if.cmd_ready, 1'b1);
        checkOutput("load_e2_dout", dout, 4'b1101);

        // Shift right by 2 with ser_in 0
        $display("[TB] shift right");
        ser_in = 1'b0;
        applyStimulus(1'b1, 2'b01, 3'd2, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        checkOutput("shr_e0_dout", dout, 4'b1101);
        tick();
        checkOutput("shr_e1_dout", dout, 4'b0110);
        checkOutput("shr_e1_done", done, 1'b0);
        tick();
        checkOutput("shr_e2_dout", dout, 4'b0011);
        checkOutput("shr_e2_done", done, 1'b1);
        checkOutput("shr_e2_ser_out_r", ser_out_r, 1'b1);
        tick();
        checkOutput("shr_e3_done", done, 1'b0);
        checkOutput("shr_e3_ready", cmd_if.cmd_ready, 1'b1);

        // Shift left by 3 with ser_in 0
        $display("[TB] shift left");
        applyStimulus(1'b1, 2'b10, 3'd3, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        tick();
        checkOutput("shl_e1_dout", dout, 4'b0110);
        checkOutput("shl_e1_ser_out_l", ser_out_l, 1'b0);
        checkOutput("shl_e1_done", done, 1'b0);
        tick();
        checkOutput("shl_e2_dout", dout, 4'b1100);
        checkOutput("shl_e2_ser_out_l", ser_out_l, 1'b1);
        checkOutput("shl_e2_done", done, 1'b0);
        tick();
        checkOutput("shl_e3_dout", dout, 4'b1000);
        checkOutput("shl_e3_ser_out_l", ser_out_l, 1'b1);
        checkOutput("shl_e3_ser_out_r", ser_out_r, 1'b0);
        checkOutput("shl_e3_done", done, 1'b1);
        tick();
        checkOutput("shl_e4_done", done, 1'b0);

        // Zero-count shift, then NOP
        $display("[TB] zero count and nop");
        applyStimulus(1'b1, 2'b01, 3'd0, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        checkOutput("zero_e0_done", done, 1'b1);
        checkOutput("zero_e0_dout", dout, 4'b1000);
        tick();
        checkOutput("zero_e1_done", done, 1'b0);
        checkOutput("zero_e1_ready", cmd_if.cmd_ready, 1'b1);
        applyStimulus(1'b1, 2'b00, 3'd5, 4'hF);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        checkOutput("nop_e0_done", done, 1'b1);
        checkOutput("nop_e0_dout", dout, 4'b1000);
        tick();
        checkOutput("nop_e1_done", done, 1'b0);
        checkOutput("nop_e1_dout", dout, 4'b1000);

        // Reset after three of seven left shifts with ser_in 1
        $display("[TB] reset mid-shift");
        ser_in = 1'b1;
        applyStimulus(1'b1, 2'b10, 3'd7, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        tick();
        checkOutput("rstmid_e1_dout", dout, 4'b0001);
        tick();
        tick();
        checkOutput("rstmid_e3_dout", dout, 4'b0111);
        checkOutput("rstmid_e3_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_async_dout", dout, 4'h0);
        checkOutput("rstmid_async_busy", busy, 1'b0);
        checkOutput("rstmid_async_done", done, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rstmid_after_done", done, 1'b0);
        checkOutput("rstmid_after_dout", dout, 4'h0);
        ser_in = 1'b0;
        applyStimulus(1'b1, 2'b11, 3'd0, 4'b1010);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        checkOutput("rstmid_next_busy", busy, 1'b1);
        tick();
        checkOutput("rstmid_next_dout", dout, 4'b1010);
        checkOutput("rstmid_next_done", done, 1'b1);
        tick();

        // Held request: one-bit right shift, valid kept high through the command
        $display("[TB] held request");
        accepts_base = accepts;
        applyStimulus(1'b1, 2'b01, 3'd1, 4'h0);
        tick();
        checkOutput("held_e0_busy", busy, 1'b1);
        tick();
        checkOutput("held_e1_dout", dout, 4'b0101);
        checkOutput("held_e1_done", done, 1'b1);
        tick();
        checkOutput("held_e2_ready", cmd_if.cmd_ready, 1'b1);
        checkOutput("held_e2_accepts", accepts - accepts_base, 1);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 4'h0);
        checkOutput("held_e3_busy", busy, 1'b1);
        checkOutput("held_e3_accepts", accepts - accepts_base, 2);
        tick();
        checkOutput("held_e4_dout", dout, 4'b0010);
        checkOutput("held_e4_done", done, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("held_final_busy", busy, 1'b0);
        checkOutput("held_final_accepts", accepts - accepts_base, 2);
        checkOutput("held_final_dout", dout, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_seq.md
USR_SEQ -- requirements
Module: usr_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, shift-register data width.
REQ-002 SHALL have parameter CNT_W, default 3, shift-count width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accept; transfer when cmd_valid&&cmd_ready at a rising edge.
REQ-007 SHALL have port cmd_op  input  2  00 NOP, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 SHALL have port cmd_count  input  CNT_W  number of shift cycles, 0..2^CNT_W-1.
REQ-009 SHALL have port cmd_data  input  WIDTH  parallel load word.
REQ-010 SHALL have port ser_in  input  1  serial input bit for shifts, sampled every shift cycle.
REQ-011 SHALL have port dout  output  WIDTH  register contents.
REQ-012 SHALL have port ser_out_l / ser_out_r  output  1 each  dout[WIDTH-1] / dout[0], combinational.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a command completes.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; cmd_ready = (state==IDLE).
REQ-016 SHALL latch cmd_op, cmd_count, cmd_data at the accept edge; later input changes have no effect on the running command.
REQ-017 SHALL transition on accept: op 11 -> LOAD; op 01/10 with count>0 -> SHIFT; op 00, or count 0 -> DONE.
REQ-018 SHALL drive the datapath select: IDLE/DONE 00 hold, SHIFT 01 (right) or 10 (left), LOAD 11.
REQ-019 SHALL in LOAD load dout <= latched data at the next edge, then go to DONE (accept E0, dout valid after E1, done high E1..E2).
REQ-020 SHALL in SHIFT right update dout <= {ser_in, dout[WIDTH-1:1]}; left update dout <= {dout[WIDTH-2:0], ser_in}.
REQ-021 SHALL load a down-counter with count at accept, decrement per shift edge, leave SHIFT for DONE on the edge where counter==1; exactly count shifts occur (dout updated at E1..En, done high En..En+1).
REQ-022 SHALL hold dout unchanged in IDLE and DONE.
REQ-023 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE; a new command is acceptable from the following edge (no back-to-back accept while busy).
REQ-024 SHALL ignore cmd_valid while cmd_ready=0; a held cmd_valid is accepted once, in the first IDLE cycle.

Reset
REQ-025 SHALL on rst high, at any time including mid-command, immediately force state IDLE, dout 0, counter 0, done 0, busy 0; the aborted command produces no done pulse.
REQ-026 SHALL accept no command while rst is high; operation resumes on the first edge after deassertion.

Structure
REQ-027 SHALL place select encodings (HOLD, SHR, SHL, LOAD) and FSM state encodings in a shared package usr_pkg.
REQ-028 SHALL split the datapath into one sub-module usr_core (clk, rst, select, p_din, ser_in, dout); usr_seq holds the FSM and counter.

Verification
REQ-029 SHALL test load: op 11, data 1101 -> dout 1101 after E1, done high one cycle E1..E2, ready low E0..E2.
REQ-030 SHALL test shift right: from 1101, op 01, count 2, ser_in 0 -> 0110 then 0011, done after second shift.
REQ-031 SHALL test shift left: from 0011, op 10, count 3, ser_in 0 -> 0110, 1100, 1000; ser_out_l matches dout[3] each cycle.
REQ-032 SHALL test zero count and NOP: op 01 count 0, then op 00 -> dout unchanged, done one cycle after each accept.
REQ-033 SHALL test reset mid-shift: op 10 count 7, assert rst after 3 shifts -> dout 0 immediately, no done, next command accepted normally.
REQ-034 SHALL test held request: cmd_valid held high across a busy command -> exactly one extra accept, first IDLE cycle after done.
